// File: rtl/gshare_bpred.sv
`default_nettype none
// ============================================================================
// Module  : gshare_bpred
// Brief   : Gshare direction predictor (2-bit PHT) with a direct-mapped BTB.
//           Optional BTB tagging is enabled by defining BPRED_BTB_TAG_EN.
// Rev     : 1.0  initial release
// ============================================================================
module gshare_bpred #(
  parameter int GHR_W     = 11,
  parameter int PHT_IDX_W = 11,
  parameter int BTB_IDX_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              lu_valid,
  input  logic [31:0]       lu_pc4,
  output logic              pred_dir,
  output logic [31:0]       pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  output logic [1:0]        pred_ctr,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc4,
  input  logic              upd_dir,
  input  logic              upd_miss,
  input  logic [31:0]       upd_target,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic [1:0]        upd_ctr,
  output logic              init_busy,
  output logic [31:0]       miss_count
);

  localparam int SWEEP_W = (PHT_IDX_W > BTB_IDX_W) ? PHT_IDX_W : BTB_IDX_W;
  localparam int PHT_N   = 1 << PHT_IDX_W;
  localparam int BTB_N   = 1 << BTB_IDX_W;
  localparam int TAG_W   = 30 - BTB_IDX_W;
  localparam logic [SWEEP_W-1:0] SWEEP_LAST = '1;

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t               r_state;
  logic [SWEEP_W-1:0]   r_sweep;
  logic [GHR_W-1:0]     r_ghr;
  logic                 r_shift_pend;

  logic [1:0]           r_pht        [PHT_N];
  logic                 r_btb_valid  [BTB_N];
  logic [29:0]          r_btb_target [BTB_N];
`ifdef BPRED_BTB_TAG_EN
  logic [TAG_W-1:0]     r_btb_tag    [BTB_N];
`endif

  logic                 w_lu_fire;
  logic                 w_pht_we;
  logic                 w_btb_we;
  logic                 w_recover;
  logic [PHT_IDX_W-1:0] w_lu_pht_idx;
  logic [BTB_IDX_W-1:0] w_lu_btb_idx;
  logic [PHT_IDX_W-1:0] w_upd_pht_idx;
  logic [BTB_IDX_W-1:0] w_upd_btb_idx;
  logic [1:0]           w_lu_ctr;
  logic                 w_btb_hit;
  logic                 w_lu_dir;
  logic [1:0]           w_ctr_next;
  logic                 w_unused;

  assign w_lu_fire = lu_valid & ~stall & ~init_busy;
  assign w_pht_we  = upd_valid & ~stall & ~init_busy;
  assign w_btb_we  = upd_valid & upd_dir & ~init_busy;
  assign w_recover = upd_valid & upd_miss & ~stall & ~init_busy;

  assign w_lu_pht_idx  = lu_pc4[PHT_IDX_W+1:2] ^ PHT_IDX_W'(r_ghr);
  assign w_lu_btb_idx  = lu_pc4[BTB_IDX_W+1:2];
  assign w_upd_pht_idx = upd_pc4[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);
  assign w_upd_btb_idx = upd_pc4[BTB_IDX_W+1:2];

  // Tables are read combinationally and written on the clock edge, so a
  // same-cycle read of a location being written returns the old contents.
  assign w_lu_ctr = r_pht[w_lu_pht_idx];

`ifdef BPRED_BTB_TAG_EN
  assign w_btb_hit = r_btb_valid[w_lu_btb_idx] &&
                     (r_btb_tag[w_lu_btb_idx] == lu_pc4[31:BTB_IDX_W+2]);
  assign w_unused  = ^{upd_pc4[1:0], upd_target[1:0]};
`else
  assign w_btb_hit = r_btb_valid[w_lu_btb_idx];
  assign w_unused  = ^{upd_pc4[31:BTB_IDX_W+2], upd_pc4[1:0], upd_target[1:0]};
`endif

  assign w_lu_dir = w_lu_ctr[1] & w_btb_hit;

  always_comb begin
    w_ctr_next = upd_ctr;
    if (upd_dir) begin
      if (upd_ctr != 2'd3) w_ctr_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != 2'd0) w_ctr_next = upd_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy) begin
      r_pht[r_sweep[PHT_IDX_W-1:0]] <= 2'b01;
    end else if (w_pht_we) begin
      r_pht[w_upd_pht_idx] <= w_ctr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (init_busy) begin
      r_btb_valid[r_sweep[BTB_IDX_W-1:0]] <= 1'b0;
    end else if (w_btb_we) begin
      r_btb_valid[w_upd_btb_idx]  <= 1'b1;
      r_btb_target[w_upd_btb_idx] <= upd_target[31:2];
`ifdef BPRED_BTB_TAG_EN
      r_btb_tag[w_upd_btb_idx]    <= upd_pc4[31:BTB_IDX_W+2];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_sweep      <= '0;
      r_ghr        <= '0;
      r_shift_pend <= 1'b0;
      init_busy    <= 1'b1;
      miss_count   <= '0;
      pred_dir     <= 1'b0;
      pred_target  <= '0;
      pred_ghr     <= '0;
      pred_ctr     <= '0;
    end else begin
      unique case (r_state)
        S_INIT: begin
          r_ghr        <= '0;
          r_shift_pend <= 1'b0;
          pred_dir     <= 1'b0;
          r_sweep      <= r_sweep + 1'b1;
          if (r_sweep == SWEEP_LAST) begin
            r_state   <= S_RUN;
            init_busy <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_lu_fire) begin
            pred_ctr    <= w_lu_ctr;
            pred_dir    <= w_lu_dir;
            pred_target <= w_lu_dir ? {r_btb_target[w_lu_btb_idx], 2'b00} : lu_pc4;
            pred_ghr    <= r_ghr;
          end

          // A recovery squashes any speculative shift still in flight,
          // including one from a lookup accepted in the same cycle.
          if (w_recover) begin
            r_ghr <= {upd_dir, upd_ghr[GHR_W-1:1]};
          end else if (r_shift_pend && !stall) begin
            r_ghr <= {pred_dir, r_ghr[GHR_W-1:1]};
          end

          if (w_recover) begin
            r_shift_pend <= 1'b0;
          end else if (w_lu_fire) begin
            r_shift_pend <= 1'b1;
          end else if (!stall) begin
            r_shift_pend <= 1'b0;
          end

          if (w_recover && (miss_count != 32'hFFFF_FFFF)) begin
            miss_count <= miss_count + 32'd1;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_bpred.sv
`default_nettype none
// Directed self-checking bench for gshare_bpred (default parameters).
module tb_gshare_bpred;

`ifdef BPRED_BTB_TAG_EN
  localparam bit TAG_EN = 1'b1;
`else
  localparam bit TAG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, lu_valid, upd_valid, upd_dir, upd_miss;
  logic [31:0] lu_pc4, upd_pc4, upd_target;
  logic [10:0] upd_ghr;
  logic [1:0]  upd_ctr;
  logic        pred_dir, init_busy;
  logic [31:0] pred_target, miss_count;
  logic [10:0] pred_ghr;
  logic [1:0]  pred_ctr;

  int n_checks = 0;
  int n_errors = 0;
  int n_init;

  gshare_bpred dut (
    .clk(clk), .reset(reset), .stall(stall),
    .lu_valid(lu_valid), .lu_pc4(lu_pc4),
    .pred_dir(pred_dir), .pred_target(pred_target),
    .pred_ghr(pred_ghr), .pred_ctr(pred_ctr),
    .upd_valid(upd_valid), .upd_pc4(upd_pc4), .upd_dir(upd_dir),
    .upd_miss(upd_miss), .upd_target(upd_target), .upd_ghr(upd_ghr),
    .upd_ctr(upd_ctr), .init_busy(init_busy), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [31:0] pc);
    lu_valid = 1'b1;
    lu_pc4   = pc;
    tick();
    lu_valid = 1'b0;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic dir, input logic miss,
                         input logic [31:0] tgt, input logic [10:0] ghr, input logic [1:0] ctr);
    upd_valid  = 1'b1;
    upd_pc4    = pc;
    upd_dir    = dir;
    upd_miss   = miss;
    upd_target = tgt;
    upd_ghr    = ghr;
    upd_ctr    = ctr;
  endtask

  task automatic update(input logic [31:0] pc, input logic dir, input logic miss,
                        input logic [31:0] tgt, input logic [10:0] ghr, input logic [1:0] ctr);
    set_upd(pc, dir, miss, tgt, ghr, ctr);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    logic [10:0] ghr_seq [5];
    ghr_seq = '{11'h000, 11'h400, 11'h600, 11'h700, 11'h780};

    reset = 1'b1; stall = 1'b0; lu_valid = 1'b0; lu_pc4 = '0;
    upd_valid = 1'b0; upd_pc4 = '0; upd_dir = 1'b0; upd_miss = 1'b0;
    upd_target = '0; upd_ghr = '0; upd_ctr = '0;

    // Reset state and initialisation length
    tick();
    check("rst_init_busy", init_busy, 1);
    check("rst_pred_dir", pred_dir, 0);
    check("rst_pred_target", pred_target, 0);
    check("rst_pred_ghr", pred_ghr, 0);
    check("rst_pred_ctr", pred_ctr, 0);
    check("rst_miss_count", miss_count, 0);
    reset = 1'b0;
    wait_init(n_init);
    check("init_cycles", n_init, 2048);

    // First lookup after initialisation: weakly not-taken, BTB empty
    lookup(32'h104);
    check("first_ctr", pred_ctr, 1);
    check("first_dir", pred_dir, 0);
    check("first_target", pred_target, 32'h104);
    check("first_ghr", pred_ghr, 0);
    tick();

    // Train 0x104 at GHR 0 (1->2->3->3), then at the GHRs the walk will see
    update(32'h104, 1'b1, 1'b0, 32'h2000, 11'h000, 2'd1);
    update(32'h104, 1'b1, 1'b0, 32'h2000, 11'h000, 2'd2);
    update(32'h104, 1'b1, 1'b0, 32'h2000, 11'h000, 2'd3);
    for (int k = 1; k < 5; k++) update(32'h104, 1'b1, 1'b0, 32'h2000, ghr_seq[k], 2'd2);

    // Five taken lookups, spaced so each sees the previous shift
    for (int k = 0; k < 5; k++) begin
      lookup(32'h104);
      check($sformatf("walk%0d_ctr", k), pred_ctr, 3);
      check($sformatf("walk%0d_dir", k), pred_dir, 1);
      check($sformatf("walk%0d_target", k), pred_target, 32'h2000);
      check($sformatf("walk%0d_ghr", k), pred_ghr, ghr_seq[k]);
      tick();
    end

    // Misprediction recovery in the same cycle as a lookup
    set_upd(32'h300, 1'b0, 1'b1, 32'h0, 11'h001, 2'd0);
    lookup(32'h104);
    upd_valid = 1'b0;
    check("walk_final_ghr", pred_ghr, 11'h7C0);
    check("recover_miss_count", miss_count, 1);
    lookup(32'h200);
    check("recover_ghr", pred_ghr, 0);
    check("recover_dir", pred_dir, 0);
    tick();

    // Same BTB index, different tag
    update(32'h104, 1'b1, 1'b0, 32'h2000, 11'h100, 2'd2);
    lookup(32'h504);
    check("alias_ctr", pred_ctr, 3);
    check("alias_dir", pred_dir, TAG_EN ? 32'd0 : 32'd1);
    check("alias_target", pred_target, TAG_EN ? 32'h504 : 32'h2000);
    update(32'h300, 1'b0, 1'b1, 32'h0, 11'h000, 2'd0);
    check("alias_miss_count", miss_count, 2);

    // Stall holds predictions, history, PHT and miss counter
    lookup(32'h104);
    check("prestall_dir", pred_dir, 1);
    check("prestall_ghr", pred_ghr, 0);
    stall = 1'b1;
    lu_valid = 1'b1; lu_pc4 = 32'h200;
    set_upd(32'h104, 1'b0, 1'b1, 32'h0, 11'h000, 2'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("stall%0d_dir", k), pred_dir, 1);
      check($sformatf("stall%0d_target", k), pred_target, 32'h2000);
      check($sformatf("stall%0d_ctr", k), pred_ctr, 3);
      check($sformatf("stall%0d_ghr", k), pred_ghr, 0);
      check($sformatf("stall%0d_miss", k), miss_count, 2);
    end
    stall = 1'b0; lu_valid = 1'b0; upd_valid = 1'b0;
    tick();
    lookup(32'h1104);
    check("poststall_ghr", pred_ghr, 11'h400);
    check("poststall_pht", pred_ctr, 3);
    tick();

    // Reset part-way through the sweep restarts it from zero
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    check("midsweep_busy", init_busy, 1);
    reset = 1'b1;
    tick();
    check("rerst_busy", init_busy, 1);
    check("rerst_miss_count", miss_count, 0);
    reset = 1'b0;
    lu_valid = 1'b1; lu_pc4 = 32'h104;
    set_upd(32'h104, 1'b1, 1'b1, 32'h3000, 11'h000, 2'd1);
    wait_init(n_init);
    lu_valid = 1'b0; upd_valid = 1'b0;
    check("reinit_cycles", n_init, 2048);
    check("reinit_ignored_ctr", pred_ctr, 0);
    check("reinit_ignored_miss", miss_count, 0);
    lookup(32'h104);
    check("reinit_ctr", pred_ctr, 1);
    check("reinit_dir", pred_dir, 0);
    check("reinit_target", pred_target, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
